uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares one UART transmit FIFO write port (`wr_uart`, `w_data`, `tx_full`) among NREQ packet sources.
- Arbitration is round-robin. A grant is held for a whole packet, from first byte to the byte marked `last`.
- Each packet can be prefixed with a one-byte channel header.
- A stalled source loses its grant after a timeout.
- The block sits between the system-side message producers and the `uart` top-level write interface.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `DBIT`, 8: data width; must be 8 when `HDR_EN`=1.
- `HDR_EN`, 1: 1 inserts a header byte before each packet.
- `TIMEOUT`, 1023: consecutive idle cycles tolerated mid-packet; 0 disables the timeout.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: per-source byte valid.
- `req_data`  in  NREQ×DBIT: per-source byte, packed [NREQ-1:0][DBIT-1:0].
- `req_last`  in  NREQ: marks the final byte of a packet.
- `req_ready`  out  NREQ: per-source accept; a byte transfers when valid&ready.
- `tx_full`  in  1: from the UART TX FIFO.
- `wr_uart`  out  1: write strobe to the UART TX FIFO.
- `w_data`  out  DBIT: byte to the UART TX FIFO.
- `grant_id`  out  $clog2(NREQ): current or most recent owner.
- `busy`  out  1: high while in HDR or DATA.
- `abort`  out  1: one-cycle pulse when a grant is revoked by timeout.

## Operation

States: IDLE, HDR, DATA. There is one registered state, a grant register, an rr pointer `last_grant`, and an idle counter.

IDLE:
- If any `req_valid` is high, select the first valid requester searching upward from `last_grant+1`, with wrap-around.
- Register that index into `grant_id`.
- Go to HDR if `HDR_EN`=1, otherwise go to DATA.
- All `req_ready` are 0 in IDLE.

HDR:
- `wr_uart` = !`tx_full`; `w_data` = 8'hA0 | `grant_id`.
- Go to DATA on the cycle the write occurs. Stay in HDR while `tx_full` is high.

DATA:
- `req_ready[g]` = !`tx_full`; all other `req_ready` bits are 0.
- `wr_uart` = `req_valid[g]` & !`tx_full`; `w_data` = `req_data[g]`.
- When a transfer occurs with `req_last[g]`=1: go to IDLE and set `last_grant` = g.

Timeout:
- The idle counter clears on any transfer and on entry to DATA.
- It increments each DATA cycle with `req_valid[g]`=0. Cycles stalled by `tx_full` with valid high do not count.
- When the counter reaches `TIMEOUT`: pulse `abort` for one cycle, go to IDLE, set `last_grant` = g.
- Bytes already written stay in the FIFO. The source must restart its packet.

Other rules:
- `w_data` is driven to 0 whenever `wr_uart` is 0.
- A requester dropping `req_valid` between bytes is legal, subject to the timeout.
- Arbitration is not pre-empted. A higher-index or newly valid source waits for the current owner to finish.

## Timing

Reset values:
- state IDLE
- `grant_id` 0
- `last_grant` NREQ-1, so requester 0 wins first
- `busy` 0, `abort` 0, `wr_uart` 0, `req_ready` 0, `w_data` 0

Reset is asynchronous and may arrive mid-packet: all registers clear immediately and the partial packet is abandoned.

Latency and throughput:
- `wr_uart`, `w_data` and `req_ready` are combinational from state, `grant_id`, `req_valid[g]` and `tx_full`. There is zero-cycle pass-through in DATA.
- An unstalled k-byte packet occupies 1 IDLE cycle, then 1 HDR cycle, then k DATA cycles. The next grant is decided on the following IDLE cycle.

Boundary cases:
- `tx_full` high on the last byte: the transfer is held and the state is unchanged until `tx_full` drops.
- `req_last` on a single-byte packet: DATA lasts 1 cycle.
- A timeout and a transfer in the same cycle cannot both occur, because a transfer clears the counter; the transfer takes priority.

## Structure

- Package `uart_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, HDR, DATA);
  - the constant `HDR_TAG` = 4'hA;
  - the function `rr_next(req, last)` returning the next index.
- Sub-module `rr_arbiter`: a combinational round-robin pick. Inputs are the request vector and `last_grant`; outputs are the index and the any-valid flag. It is instantiated once.

## Test plan

- Reset, then source 2 sends 3 bytes 11,22,33 (last on 33) with `tx_full`=0:
  - `w_data` sequence is A2,11,22,33 on consecutive `wr_uart` cycles;
  - `busy` is high for 4 cycles;
  - `grant_id`=2.
- All 4 sources valid with 1-byte packets: headers appear in order A0,A1,A2,A3, then wrap back to A0.
- `tx_full` held high for 5 cycles mid-packet: no `wr_uart`, `req_ready`=0, no `abort`; the stream resumes byte-exact.
- `TIMEOUT`=8 and the owner drops valid after 1 byte: `abort` pulses exactly 8 cycles later, and the next valid source is granted.
- `reset_n` asserted during DATA: outputs return to reset values in the same cycle; after release, requester 0 wins first.
- `HDR_EN`=0: the packet from source 1 produces only payload bytes, with the first byte written on the cycle after IDLE.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types, constants and the round-robin search helper for the UART TX arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StData
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;
   localparam int unsigned RR_MAX = 16;

   // Unused upper request bits must be zero; the search then wraps modulo RR_MAX and
   // lands on the correct index for any NREQ up to RR_MAX.
   function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] req, input logic [3:0] last);
      logic [3:0] idx;
      rr_next = last;
      for (int i = RR_MAX; i >= 1; i--) begin
         idx = last + 4'(i);
         if (req[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request above last_grant, wrapping around.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_last,
   output logic [$clog2(NREQ)-1:0] o_idx,
   output logic                    o_any
);

   localparam int unsigned GW = $clog2(NREQ);

   logic [3:0] w_idx;

   assign w_idx = rr_next(RR_MAX'(i_req), 4'(i_last));
   assign o_idx = GW'(w_idx);
   assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART TX FIFO write port among NREQ sources,
// with an optional channel header byte and a mid-packet stall timeout.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DBIT    = 8,
   parameter int unsigned HDR_EN  = 1,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic [NREQ-1:0]            i_req_valid,
   input  logic [NREQ-1:0][DBIT-1:0]  i_req_data,
   input  logic [NREQ-1:0]            i_req_last,
   output logic [NREQ-1:0]            o_req_ready,
   input  logic                       i_tx_full,
   output logic                       o_wr_uart,
   output logic [DBIT-1:0]            o_w_data,
   output logic [$clog2(NREQ)-1:0]    o_grant_id,
   output logic                       o_busy,
   output logic                       o_abort
);

   localparam int unsigned GW = $clog2(NREQ);
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

   arb_state_t      r_state;
   arb_state_t      w_state_next;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   w_grant_next;
   logic [GW-1:0]   r_last_grant;
   logic [GW-1:0]   w_last_next;
   logic [CW-1:0]   r_idle_cnt;
   logic [CW-1:0]   w_cnt_next;

   logic [GW-1:0]   w_pick;
   logic            w_any;
   logic            w_sel_valid;
   logic            w_sel_last;
   logic [DBIT-1:0] w_sel_data;
   logic [DBIT-1:0] w_hdr;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .i_req  (i_req_valid),
      .i_last (r_last_grant),
      .o_idx  (w_pick),
      .o_any  (w_any)
   );

   assign w_sel_valid = i_req_valid[r_grant];
   assign w_sel_last  = i_req_last[r_grant];
   assign w_sel_data  = i_req_data[r_grant];
   assign w_hdr       = DBIT'({HDR_TAG, 4'(r_grant)});

   assign o_grant_id = r_grant;
   assign o_busy     = (r_state != StIdle);

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_last_next  = r_last_grant;
      w_cnt_next   = '0;
      o_req_ready  = '0;
      o_wr_uart    = 1'b0;
      o_w_data     = '0;
      o_abort      = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_any) begin
               w_grant_next = w_pick;
               w_state_next = (HDR_EN != 0) ? StHdr : StData;
            end
         end
         StHdr: begin
            if (!i_tx_full) begin
               o_wr_uart    = 1'b1;
               o_w_data     = w_hdr;
               w_state_next = StData;
            end
         end
         StData: begin
            o_req_ready[r_grant] = !i_tx_full;
            if (w_sel_valid && !i_tx_full) begin
               o_wr_uart = 1'b1;
               o_w_data  = w_sel_data;
               if (w_sel_last) begin
                  w_state_next = StIdle;
                  w_last_next  = r_grant;
               end
            end else if (w_sel_valid) begin
               // FIFO back-pressure is not the source's fault: hold the count
               w_cnt_next = r_idle_cnt;
            end else if ((TIMEOUT != 0) && (r_idle_cnt == CNT_LIMIT)) begin
               o_abort      = 1'b1;
               w_state_next = StIdle;
               w_last_next  = r_grant;
            end else begin
               w_cnt_next = r_idle_cnt + CW'(1);
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_grant      <= '0;
         r_last_grant <= GW'(NREQ - 1);
         r_idle_cnt   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_next;
         r_idle_cnt   <= w_cnt_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a queue-fed source model, a write scoreboard,
// a table of DATA-state output vectors and hand-written multi-cycle corner sequences.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DBIT = 8;
   localparam int unsigned TO   = 8;

   typedef struct {
      logic [NREQ-1:0] valid;
      logic            last1;
      logic            full;
      logic [DBIT-1:0] d1;
      logic            exp_wr;
      logic [DBIT-1:0] exp_wd;
      logic [NREQ-1:0] exp_ready;
      logic            exp_busy;
   } vec_t;

   logic                      clk;
   logic                      rst_a;
   logic                      rst_b;
   logic                      use_b;
   logic [NREQ-1:0]           valid;
   logic [NREQ-1:0]           last;
   logic [NREQ-1:0][DBIT-1:0] data;
   logic                      full;

   logic [NREQ-1:0] ready_a, ready_b, cur_ready;
   logic            wr_a, wr_b, cur_wr;
   logic [DBIT-1:0] wd_a, wd_b, cur_wd;
   logic [1:0]      gid_a, gid_b;
   logic            busy_a, busy_b, cur_busy;
   logic            abort_a, abort_b, cur_abort;

   int checks;
   int failures;
   int cyc;
   int busy_cnt;
   int abort_cnt;
   int abort_cyc;
   int wr_cyc[$];
   logic [DBIT-1:0] exp_q[$];

   logic [8:0] src_mem [NREQ][16];
   int         src_hd  [NREQ];
   int         src_tl  [NREQ];

   vec_t vecs [9];

   uart_tx_arbiter #(
      .NREQ (NREQ), .DBIT (DBIT), .HDR_EN (1), .TIMEOUT (TO)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_a),
      .i_req_valid (valid),
      .i_req_data  (data),
      .i_req_last  (last),
      .o_req_ready (ready_a),
      .i_tx_full   (full),
      .o_wr_uart   (wr_a),
      .o_w_data    (wd_a),
      .o_grant_id  (gid_a),
      .o_busy      (busy_a),
      .o_abort     (abort_a)
   );

   uart_tx_arbiter #(
      .NREQ (NREQ), .DBIT (DBIT), .HDR_EN (0), .TIMEOUT (TO)
   ) dut_nh (
      .i_clk       (clk),
      .i_reset_n   (rst_b),
      .i_req_valid (valid),
      .i_req_data  (data),
      .i_req_last  (last),
      .o_req_ready (ready_b),
      .i_tx_full   (full),
      .o_wr_uart   (wr_b),
      .o_w_data    (wd_b),
      .o_grant_id  (gid_b),
      .o_busy      (busy_b),
      .o_abort     (abort_b)
   );

   assign cur_ready = use_b ? ready_b : ready_a;
   assign cur_wr    = use_b ? wr_b    : wr_a;
   assign cur_wd    = use_b ? wd_b    : wd_a;
   assign cur_busy  = use_b ? busy_b  : busy_a;
   assign cur_abort = use_b ? abort_b : abort_a;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_src(input int s, input logic lst, input logic [7:0] d);
      src_mem[s][src_tl[s]] = {lst, d};
      src_tl[s]++;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (src_hd[i] < src_tl[i]) begin
            valid[i] = 1'b1;
            last[i]  = src_mem[i][src_hd[i]][8];
            data[i]  = src_mem[i][src_hd[i]][7:0];
         end else begin
            valid[i] = 1'b0;
            last[i]  = 1'b0;
            data[i]  = '0;
         end
      end
   endtask

   task automatic scen_init();
      cyc       = 0;
      busy_cnt  = 0;
      abort_cnt = 0;
      abort_cyc = -1;
      wr_cyc.delete();
   endtask

   // One clock: sample at negedge, score writes, then advance the sources after posedge.
   task automatic step();
      logic [NREQ-1:0] hs;
      @(negedge clk);
      hs = valid & cur_ready;
      if (cur_busy) busy_cnt++;
      if (cur_abort) begin
         abort_cnt++;
         abort_cyc = cyc;
      end
      if (cur_wr) begin
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra actual=%0h required=no_write", cur_wd);
         end else begin
            check("sb_data", 32'(cur_wd), 32'(exp_q.pop_front()));
         end
      end else begin
         check("wdata_idle_zero", 32'(cur_wd), 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) src_hd[i]++;
      drive();
      cyc++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic hard_reset(input logic to_b);
      rst_a = 1'b0;
      rst_b = 1'b0;
      full  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         src_hd[i] = 0;
         src_tl[i] = 0;
      end
      valid = '0;
      last  = '0;
      data  = '0;
      exp_q.delete();
      use_b = to_b;
      repeat (2) @(posedge clk);
      #1;
      if (to_b) rst_b = 1'b1;
      else rst_a = 1'b1;
      scen_init();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0010, 1'b1};
      vecs[1] = '{4'b1111, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 4'b0010, 1'b1};
      vecs[2] = '{4'b0010, 1'b0, 1'b1, 8'h4D, 1'b0, 8'h00, 4'b0000, 1'b1};
      vecs[3] = '{4'b1101, 1'b0, 1'b0, 8'h5E, 1'b0, 8'h00, 4'b0010, 1'b1};
      vecs[4] = '{4'b1101, 1'b0, 1'b1, 8'h5E, 1'b0, 8'h00, 4'b0000, 1'b1};
      vecs[5] = '{4'b0010, 1'b0, 1'b0, 8'hE7, 1'b1, 8'hE7, 4'b0010, 1'b1};
      vecs[6] = '{4'b0010, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 4'b0000, 1'b1};
      vecs[7] = '{4'b0010, 1'b1, 1'b0, 8'h99, 1'b1, 8'h99, 4'b0010, 1'b1};
      vecs[8] = '{4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0};

      // Reset values
      hard_reset(1'b0);
      #1;
      check("rst_busy", 32'(busy_a), 0);
      check("rst_wr", 32'(wr_a), 0);
      check("rst_ready", 32'(ready_a), 0);
      check("rst_wdata", 32'(wd_a), 0);
      check("rst_abort", 32'(abort_a), 0);
      check("rst_grant", 32'(gid_a), 0);

      // Source 2 sends 11,22,33
      hard_reset(1'b0);
      push_src(2, 1'b0, 8'h11);
      push_src(2, 1'b0, 8'h22);
      push_src(2, 1'b1, 8'h33);
      exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
      drive();
      run(8);
      check("s1_busy_cycles", 32'(busy_cnt), 4);
      check("s1_grant", 32'(gid_a), 2);
      check("s1_wr_count", 32'(wr_cyc.size()), 4);
      check("s1_first_wr", 32'(wr_cyc[0]), 1);
      check("s1_span", 32'(wr_cyc[3] - wr_cyc[0]), 3);
      check("s1_drain", 32'(exp_q.size()), 0);

      // DATA-state output table with source 1 holding the grant
      hard_reset(1'b0);
      push_src(1, 1'b0, 8'h10);
      exp_q = '{8'hA1, 8'h10};
      drive();
      run(3);
      check("tbl_setup_drain", 32'(exp_q.size()), 0);
      for (int r = 0; r < 9; r++) begin
         valid   = vecs[r].valid;
         last    = {2'b00, vecs[r].last1, 1'b0};
         full    = vecs[r].full;
         data[0] = 8'hD0;
         data[1] = vecs[r].d1;
         data[2] = 8'hD2;
         data[3] = 8'hD3;
         #1;
         check($sformatf("vec%0d_wr", r), 32'(wr_a), 32'(vecs[r].exp_wr));
         check($sformatf("vec%0d_wdata", r), 32'(wd_a), 32'(vecs[r].exp_wd));
         check($sformatf("vec%0d_ready", r), 32'(ready_a), 32'(vecs[r].exp_ready));
         check($sformatf("vec%0d_busy", r), 32'(busy_a), 32'(vecs[r].exp_busy));
         check($sformatf("vec%0d_abort", r), 32'(abort_a), 0);
         check($sformatf("vec%0d_grant", r), 32'(gid_a), 1);
         @(posedge clk);
         #1;
      end
      full = 1'b0;

      // All four sources with 1-byte packets, source 0 twice: wrap back to A0
      hard_reset(1'b0);
      for (int i = 0; i < NREQ; i++) begin
         push_src(i, 1'b1, 8'(8'h40 + i));
         exp_q.push_back(8'(8'hA0 + i));
         exp_q.push_back(8'(8'h40 + i));
      end
      push_src(0, 1'b1, 8'h50);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'h50);
      drive();
      run(20);
      check("s2_wr_count", 32'(wr_cyc.size()), 10);
      check("s2_grant", 32'(gid_a), 0);
      check("s2_drain", 32'(exp_q.size()), 0);

      // tx_full held mid-packet for longer than TIMEOUT: stalls never count as idle
      hard_reset(1'b0);
      push_src(1, 1'b0, 8'h71);
      push_src(1, 1'b0, 8'h72);
      push_src(1, 1'b0, 8'h73);
      push_src(1, 1'b1, 8'h74);
      exp_q = '{8'hA1, 8'h71, 8'h72, 8'h73, 8'h74};
      drive();
      run(3);
      for (int k = 0; k < 10; k++) begin
         full = 1'b1;
         #1;
         check("s3_stall_wr", 32'(wr_a), 0);
         check("s3_stall_ready", 32'(ready_a), 0);
         check("s3_stall_abort", 32'(abort_a), 0);
         step();
      end
      full = 1'b0;
      run(8);
      check("s3_abort_cnt", 32'(abort_cnt), 0);
      check("s3_grant", 32'(gid_a), 1);
      check("s3_drain", 32'(exp_q.size()), 0);

      // Owner drops valid after one byte: abort TIMEOUT cycles later, then source 2
      hard_reset(1'b0);
      push_src(0, 1'b0, 8'h01);
      push_src(2, 1'b1, 8'h2B);
      exp_q = '{8'hA0, 8'h01, 8'hA2, 8'h2B};
      drive();
      run(20);
      check("s4_abort_cnt", 32'(abort_cnt), 1);
      check("s4_abort_delay", 32'(abort_cyc - wr_cyc[1]), TO);
      check("s4_grant", 32'(gid_a), 2);
      check("s4_drain", 32'(exp_q.size()), 0);

      // Reset asserted in DATA: outputs clear at once, requester 0 wins first afterwards
      hard_reset(1'b0);
      push_src(1, 1'b0, 8'h81);
      push_src(1, 1'b0, 8'h82);
      push_src(1, 1'b0, 8'h83);
      push_src(1, 1'b1, 8'h84);
      exp_q = '{8'hA1, 8'h81};
      drive();
      run(3);
      check("s5_pre_wr", 32'(wr_a), 1);
      rst_a = 1'b0;
      #1;
      check("s5_rst_busy", 32'(busy_a), 0);
      check("s5_rst_wr", 32'(wr_a), 0);
      check("s5_rst_ready", 32'(ready_a), 0);
      check("s5_rst_wdata", 32'(wd_a), 0);
      check("s5_rst_grant", 32'(gid_a), 0);
      check("s5_rst_drain", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         src_hd[i] = 0;
         src_tl[i] = 0;
      end
      push_src(3, 1'b1, 8'h3C);
      push_src(0, 1'b1, 8'h0C);
      exp_q = '{8'hA0, 8'h0C, 8'hA3, 8'h3C};
      scen_init();
      drive();
      rst_a = 1'b1;
      run(10);
      check("s5_grant", 32'(gid_a), 3);
      check("s5_drain", 32'(exp_q.size()), 0);

      // Header disabled: payload only, first write on the cycle after IDLE
      hard_reset(1'b1);
      push_src(1, 1'b0, 8'h91);
      push_src(1, 1'b1, 8'h92);
      exp_q = '{8'h91, 8'h92};
      drive();
      run(6);
      check("s6_first_wr", 32'(wr_cyc[0]), 1);
      check("s6_busy_cycles", 32'(busy_cnt), 2);
      check("s6_grant", 32'(gid_b), 1);
      check("s6_drain", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
